// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded instruction from ID, forwarding taps
// from EX/MEM and MEM/WB, and operands/control presented to EX.
interface id_ex_stage_if #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [WORD_WIDTH-1:0] rs_data;
  logic [WORD_WIDTH-1:0] rt_data;
  logic [WORD_WIDTH-1:0] imm;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [1:0]            alu_op;
  logic                  alu_src;
  logic                  reg_dst;
  logic                  reg_write_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic                  mem_to_reg_in;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [WORD_WIDTH-1:0] exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [WORD_WIDTH-1:0] memwb_result;
  logic [WORD_WIDTH-1:0] a_operand;
  logic [WORD_WIDTH-1:0] b_operand;
  logic [4:0]            sa;
  logic [3:0]            alu_opcode;
  logic [WORD_WIDTH-1:0] store_data;
  logic [REG_ADDR_W-1:0] dest_addr;
  logic                  ex_valid;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_to_reg;

  modport master (
    output stall, flush, id_valid,
    output rs_data, rt_data, imm,
    output rs_addr, rt_addr, rd_addr,
    output shamt, funct, alu_op,
    output alu_src, reg_dst,
    output reg_write_in, mem_read_in,
    output mem_write_in, mem_to_reg_in,
    output exmem_reg_write, exmem_rd,
    output exmem_result,
    output memwb_reg_write, memwb_rd,
    output memwb_result,
    input  a_operand, b_operand, sa,
    input  alu_opcode, store_data,
    input  dest_addr, ex_valid,
    input  reg_write, mem_read,
    input  mem_write, mem_to_reg
  );

  modport slave (
    input  stall, flush, id_valid,
    input  rs_data, rt_data, imm,
    input  rs_addr, rt_addr, rd_addr,
    input  shamt, funct, alu_op,
    input  alu_src, reg_dst,
    input  reg_write_in, mem_read_in,
    input  mem_write_in, mem_to_reg_in,
    input  exmem_reg_write, exmem_rd,
    input  exmem_result,
    input  memwb_reg_write, memwb_rd,
    input  memwb_result,
    output a_operand, b_operand, sa,
    output alu_opcode, store_data,
    output dest_addr, ex_valid,
    output reg_write, mem_read,
    output mem_write, mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU opcode decode and
// EX/MEM, MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] rs_data;
    logic [WORD_WIDTH-1:0] rt_data;
    logic [WORD_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [4:0]            sa;
    logic [3:0]            op;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } ex_t;

  ex_t st_q, st_d;
  logic [3:0] op_dec;
  logic ex_rs_hit, ex_rt_hit;
  logic wb_rs_hit, wb_rt_hit;
  logic [WORD_WIDTH-1:0] rs_fwd, rt_fwd;

  always_comb begin
    op_dec = 4'b1111;
    unique case (bus.alu_op)
      2'b00: op_dec = 4'b0010;
      2'b01: op_dec = 4'b0110;
      2'b11: op_dec = 4'b0001;
      2'b10: begin
        case (bus.funct)
          6'b100100: op_dec = 4'b0000;
          6'b100101: op_dec = 4'b0001;
          6'b100000,
          6'b100001: op_dec = 4'b0010;
          6'b100110: op_dec = 4'b0011;
          6'b000000: op_dec = 4'b0100;
          6'b100010,
          6'b100011: op_dec = 4'b0110;
          6'b101010: op_dec = 4'b0111;
          6'b100111: op_dec = 4'b1100;
          default:   op_dec = 4'b1111;
        endcase
      end
    endcase
  end

  // Register 0 is hard-wired; never forward into it.
  assign ex_rs_hit = bus.exmem_reg_write
                  && (bus.exmem_rd != '0)
                  && (bus.exmem_rd == st_q.rs);
  assign ex_rt_hit = bus.exmem_reg_write
                  && (bus.exmem_rd != '0)
                  && (bus.exmem_rd == st_q.rt);
  assign wb_rs_hit = bus.memwb_reg_write
                  && (bus.memwb_rd != '0)
                  && (bus.memwb_rd == st_q.rs);
  assign wb_rt_hit = bus.memwb_reg_write
                  && (bus.memwb_rd != '0)
                  && (bus.memwb_rd == st_q.rt);

  assign rs_fwd = ex_rs_hit ? bus.exmem_result
                : wb_rs_hit ? bus.memwb_result
                : st_q.rs_data;
  assign rt_fwd = ex_rt_hit ? bus.exmem_result
                : wb_rt_hit ? bus.memwb_result
                : st_q.rt_data;

  always_comb begin
    st_d = st_q;
    if (bus.flush) begin
      st_d    = '0;
      st_d.op = 4'b0010;
    end else if (bus.stall) begin
      // Absorb writebacks so a long stall cannot lose them.
      if (wb_rs_hit) st_d.rs_data = bus.memwb_result;
      if (wb_rt_hit) st_d.rt_data = bus.memwb_result;
    end else if (!bus.id_valid) begin
      st_d    = '0;
      st_d.op = 4'b0010;
    end else begin
      st_d.valid      = 1'b1;
      st_d.rs_data    = bus.rs_data;
      st_d.rt_data    = bus.rt_data;
      st_d.imm        = bus.imm;
      st_d.rs         = bus.rs_addr;
      st_d.rt         = bus.rt_addr;
      st_d.dest       = bus.reg_dst ? bus.rd_addr
                                    : bus.rt_addr;
      st_d.sa         = bus.shamt;
      st_d.op         = op_dec;
      st_d.alu_src    = bus.alu_src;
      st_d.reg_write  = bus.reg_write_in;
      st_d.mem_read   = bus.mem_read_in;
      st_d.mem_write  = bus.mem_write_in;
      st_d.mem_to_reg = bus.mem_to_reg_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= '0;
      st_q.op <= 4'b0010;
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.a_operand  = rs_fwd;
  assign bus.b_operand  = st_q.alu_src ? st_q.imm : rt_fwd;
  assign bus.store_data = rt_fwd;
  assign bus.sa         = st_q.sa;
  assign bus.alu_opcode = st_q.op;
  assign bus.dest_addr  = st_q.dest;
  assign bus.ex_valid   = st_q.valid;
  assign bus.reg_write  = st_q.reg_write;
  assign bus.mem_read   = st_q.mem_read;
  assign bus.mem_write  = st_q.mem_write;
  assign bus.mem_to_reg = st_q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized
// run against a behavioural pipeline-register model.
module tb_id_ex_stage;
  logic clk;
  logic reset;
  int checks;
  int errors;

  id_ex_stage_if #(.WORD_WIDTH(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(.WORD_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the stage should be holding.
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest, m_sa;
  logic [3:0]  m_op;
  logic [3:0]  lut [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 0;
    bus.exmem_rd        = 0;
    bus.exmem_result    = 0;
    bus.memwb_reg_write = 0;
    bus.memwb_rd        = 0;
    bus.memwb_result    = 0;
  endtask

  // ctl = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}
  task automatic drive_id(
    input logic [31:0] rsd, input logic [31:0] rtd,
    input logic [31:0] im, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh, input logic [5:0] fn,
    input logic [1:0] op, input logic [5:0] ctl
  );
    bus.id_valid      = 1;
    bus.rs_data       = rsd;
    bus.rt_data       = rtd;
    bus.imm           = im;
    bus.rs_addr       = rs;
    bus.rt_addr       = rt;
    bus.rd_addr       = rd;
    bus.shamt         = sh;
    bus.funct         = fn;
    bus.alu_op        = op;
    bus.alu_src       = ctl[5];
    bus.reg_dst       = ctl[4];
    bus.reg_write_in  = ctl[3];
    bus.mem_read_in   = ctl[2];
    bus.mem_write_in  = ctl[1];
    bus.mem_to_reg_in = ctl[0];
  endtask

  function automatic logic [3:0] model_op(logic [1:0] op,
                                          logic [5:0] fn);
    if (op == 2'b00) return 4'd2;
    if (op == 2'b01) return 4'd6;
    if (op == 2'b11) return 4'd1;
    return lut[fn];
  endfunction

  function automatic logic [31:0] model_fwd(logic [4:0] a,
                                            logic [31:0] d);
    if (a == 0) return d;
    if (bus.exmem_reg_write && bus.exmem_rd == a)
      return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == a)
      return bus.memwb_result;
    return d;
  endfunction

  task automatic model_reset();
    {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} = '0;
    {m_rsd, m_rtd, m_imm} = '0;
    {m_rs, m_rt, m_dest, m_sa} = '0;
    m_op = 4'd2;
  endtask

  task automatic test_reset();
    bus.stall = 0;
    bus.flush = 0;
    clear_fwd();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    #12;
    checks++;
    if (bus.ex_valid !== 0 || bus.alu_opcode !== 4'b0010
        || bus.a_operand !== 0 || bus.b_operand !== 0
        || bus.dest_addr !== 0 || bus.sa !== 0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b op=%b a=%h b=%h, want 0 0010 0 0",
               bus.ex_valid, bus.alu_opcode,
               bus.a_operand, bus.b_operand);
    end
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_decode_slt();
    clear_fwd();
    drive_id(5, 9, 32'h77, 1, 2, 4, 3, 6'b101010, 2'b10,
             6'b011000);
    tick();
    checks++;
    if (bus.alu_opcode !== 4'b0111 || bus.a_operand !== 5
        || bus.b_operand !== 9 || bus.ex_valid !== 1) begin
      errors++;
      $display("FAIL decode_slt: op=%b a=%0d b=%0d v=%0b, want 0111 5 9 1",
               bus.alu_opcode, bus.a_operand, bus.b_operand,
               bus.ex_valid);
    end
    checks++;
    if (bus.dest_addr !== 4 || bus.sa !== 3
        || bus.reg_write !== 1) begin
      errors++;
      $display("FAIL decode_ctl: dest=%0d sa=%0d rw=%0b, want 4 3 1",
               bus.dest_addr, bus.sa, bus.reg_write);
    end
  endtask

  task automatic test_reset_midrun();
    #2;
    reset = 1;
    #1;
    checks++;
    if (bus.ex_valid !== 0 || bus.alu_opcode !== 4'b0010
        || bus.a_operand !== 0 || bus.b_operand !== 0
        || bus.store_data !== 0 || bus.dest_addr !== 0
        || bus.reg_write !== 0 || bus.sa !== 0) begin
      errors++;
      $display("FAIL reset_midrun: v=%0b op=%b a=%h b=%h d=%0d, want 0 0010 0 0 0",
               bus.ex_valid, bus.alu_opcode, bus.a_operand,
               bus.b_operand, bus.dest_addr);
    end
    #1;
    reset = 0;
    tick();
  endtask

  task automatic test_forwarding();
    clear_fwd();
    drive_id(32'h33, 32'h0, 0, 3, 6, 6, 0, 6'b100000, 2'b10,
             6'b011000);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 3;
    bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1; bus.memwb_rd = 3;
    bus.memwb_result = 32'h22;
    #1;
    checks++;
    if (bus.a_operand !== 32'h11) begin
      errors++;
      $display("FAIL fwd_exmem_wins: a=%h, want 11", bus.a_operand);
    end
    bus.exmem_reg_write = 0;
    #1;
    checks++;
    if (bus.a_operand !== 32'h22) begin
      errors++;
      $display("FAIL fwd_memwb: a=%h, want 22", bus.a_operand);
    end
    bus.memwb_reg_write = 0;
    #1;
    checks++;
    if (bus.a_operand !== 32'h33) begin
      errors++;
      $display("FAIL fwd_none: a=%h, want 33", bus.a_operand);
    end
    drive_id(32'h44, 32'h0, 0, 0, 6, 6, 0, 6'b100000, 2'b10,
             6'b011000);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 0;
    bus.memwb_reg_write = 1; bus.memwb_rd = 0;
    #1;
    checks++;
    if (bus.a_operand !== 32'h44) begin
      errors++;
      $display("FAIL fwd_r0: a=%h, want 44", bus.a_operand);
    end
    clear_fwd();
  endtask

  task automatic test_stall_writeback();
    clear_fwd();
    drive_id(32'h1, 32'h70, 32'h5, 2, 7, 9, 9, 6'b100111, 2'b10,
             6'b011001);
    tick();
    bus.stall = 1;
    drive_id(32'hDEAD, 32'hBEEF, 32'h9, 1, 1, 1, 1, 6'b000000,
             2'b01, 6'b100110);
    tick();
    bus.memwb_reg_write = 1; bus.memwb_rd = 7;
    bus.memwb_result = 32'hAB;
    tick();
    clear_fwd();
    tick();
    checks++;
    if (bus.b_operand !== 32'hAB || bus.store_data !== 32'hAB) begin
      errors++;
      $display("FAIL stall_wb_kept: b=%h st=%h, want ab ab",
               bus.b_operand, bus.store_data);
    end
    checks++;
    if (bus.sa !== 9 || bus.alu_opcode !== 4'b1100
        || bus.ex_valid !== 1 || bus.reg_write !== 1
        || bus.mem_to_reg !== 1 || bus.dest_addr !== 9
        || bus.a_operand !== 1) begin
      errors++;
      $display("FAIL stall_hold: sa=%0d op=%b v=%0b d=%0d a=%h, want 9 1100 1 9 1",
               bus.sa, bus.alu_opcode, bus.ex_valid,
               bus.dest_addr, bus.a_operand);
    end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.stall = 0;
    checks++;
    if (bus.ex_valid !== 0 || bus.reg_write !== 0
        || bus.mem_write !== 0 || bus.dest_addr !== 0) begin
      errors++;
      $display("FAIL stall_flush: v=%0b rw=%0b mw=%0b d=%0d, want 0 0 0 0",
               bus.ex_valid, bus.reg_write, bus.mem_write,
               bus.dest_addr);
    end
  endtask

  task automatic test_store();
    clear_fwd();
    drive_id(32'h8, 32'h55, 32'hFFFFFFFC, 4, 5, 0, 0, 6'b0,
             2'b00, 6'b100010);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5;
    bus.exmem_result = 32'h1234;
    #1;
    checks++;
    if (bus.alu_opcode !== 4'b0010 || bus.b_operand !== 32'hFFFFFFFC
        || bus.store_data !== 32'h1234 || bus.mem_write !== 1) begin
      errors++;
      $display("FAIL store: op=%b b=%h st=%h mw=%0b, want 0010 fffffffc 1234 1",
               bus.alu_opcode, bus.b_operand, bus.store_data,
               bus.mem_write);
    end
    clear_fwd();
    bus.id_valid = 0;
    tick();
    checks++;
    if (bus.ex_valid !== 0 || bus.mem_write !== 0
        || bus.dest_addr !== 0) begin
      errors++;
      $display("FAIL invalid_id: v=%0b mw=%0b d=%0d, want 0 0 0",
               bus.ex_valid, bus.mem_write, bus.dest_addr);
    end
  endtask

  task automatic test_random();
    logic [114:0] got, exp;
    logic [31:0]  eb, ert;
    bus.stall = 0;
    bus.flush = 0;
    @(negedge clk);
    reset = 1;
    #1;
    reset = 0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      drive_id($urandom, $urandom, $urandom,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), 5'($urandom),
               6'($urandom), 2'($urandom), 6'($urandom));
      bus.id_valid = ($urandom_range(0, 7) != 0);
      bus.exmem_reg_write = 1'($urandom);
      bus.exmem_rd = 5'($urandom_range(0, 3));
      bus.exmem_result = $urandom;
      bus.memwb_reg_write = 1'($urandom);
      bus.memwb_rd = 5'($urandom_range(0, 3));
      bus.memwb_result = $urandom;
      if (bus.alu_op == 2'b10 && $urandom_range(0, 1) == 1)
        bus.funct = 6'b100000 | 6'($urandom_range(0, 10));
      #1;
      ert = model_fwd(m_rt, m_rtd);
      eb  = m_src ? m_imm : ert;
      exp = {model_fwd(m_rs, m_rsd), eb, ert, m_sa, m_op, m_dest,
             m_valid, m_rw, m_mr, m_mw, m_m2r};
      got = {bus.a_operand, bus.b_operand, bus.store_data, bus.sa,
             bus.alu_opcode, bus.dest_addr, bus.ex_valid,
             bus.reg_write, bus.mem_read, bus.mem_write,
             bus.mem_to_reg};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got=%h want=%h", n, got, exp);
      end
      if (bus.flush || (!bus.stall && !bus.id_valid)) begin
        model_reset();
      end else if (bus.stall) begin
        if (bus.memwb_reg_write && bus.memwb_rd != 0
            && bus.memwb_rd == m_rs) m_rsd = bus.memwb_result;
        if (bus.memwb_reg_write && bus.memwb_rd != 0
            && bus.memwb_rd == m_rt) m_rtd = bus.memwb_result;
      end else begin
        m_valid = 1;
        m_rsd = bus.rs_data; m_rtd = bus.rt_data;
        m_imm = bus.imm;
        m_rs = bus.rs_addr; m_rt = bus.rt_addr;
        m_dest = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
        m_sa = bus.shamt;
        m_op = model_op(bus.alu_op, bus.funct);
        m_src = bus.alu_src;
        m_rw = bus.reg_write_in; m_mr = bus.mem_read_in;
        m_mw = bus.mem_write_in; m_m2r = bus.mem_to_reg_in;
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) lut[i] = 4'hF;
    lut[36] = 4'h0; lut[37] = 4'h1; lut[32] = 4'h2;
    lut[33] = 4'h2; lut[38] = 4'h3; lut[0]  = 4'h4;
    lut[34] = 4'h6; lut[35] = 4'h6; lut[42] = 4'h7;
    lut[39] = 4'hC;
    test_reset();
    test_decode_slt();
    test_reset_midrun();
    test_forwarding();
    test_stall_writeback();
    test_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-stage operand unit. It captures the decoded instruction from ID and derives the 4-bit ALU opcode from alu_op/funct. It applies EX/MEM and MEM/WB forwarding and presents operands, shift amount and opcode directly to the ALU. It also carries the memory and writeback control bits toward the EX/MEM register.

Parameters:
WORD_WIDTH, 32, datapath width of operands and results
REG_ADDR_W, 5, register-file address width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold current contents (load-use hazard from hazard unit)
flush  input  1  load a bubble on the next edge (branch taken)
id_valid  input  1  ID slot holds a real instruction
rs_data  input  WORD_WIDTH  register-file read port A
rt_data  input  WORD_WIDTH  register-file read port B
imm  input  WORD_WIDTH  sign-extended immediate
rs_addr, rt_addr, rd_addr  input  REG_ADDR_W each  source and destination register numbers
shamt  input  5  instruction shift amount
funct  input  6  R-type function field
alu_op  input  2  main-control ALU class
alu_src, reg_dst, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  input  1 each  main-control bits
exmem_reg_write  input  1  EX/MEM stage writes a register
exmem_rd  input  REG_ADDR_W  EX/MEM destination
exmem_result  input  WORD_WIDTH  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB stage writes a register
memwb_rd  input  REG_ADDR_W  MEM/WB destination
memwb_result  input  WORD_WIDTH  writeback value
a_operand  output  WORD_WIDTH  ALU a_input
b_operand  output  WORD_WIDTH  ALU b_input
sa  output  5  ALU shift amount
alu_opcode  output  4  ALU opcode
store_data  output  WORD_WIDTH  forwarded rt, for stores
dest_addr  output  REG_ADDR_W  writeback destination
ex_valid, reg_write, mem_read, mem_write, mem_to_reg  output  1 each  registered control

Behaviour:
- Reset (async, active-high): every register clears. ex_valid, all control bits, sa, dest_addr and stored data read 0; alu_opcode = 4'b0010.
- Latency: 1 cycle. ID inputs sampled on a rising edge appear at the outputs after that edge.
- Priority at each edge: reset > flush > stall > load.
- Flush: loads a bubble. ex_valid=0; reg_write/mem_read/mem_write/mem_to_reg=0; dest_addr=0. Data fields are don't-care but are loaded with 0.
- Stall: all fields hold. Exception: if memwb_reg_write and memwb_rd!=0 and memwb_rd equals the held rs (rt), the held rs_data (rt_data) register is overwritten with memwb_result. A writeback during a multi-cycle stall is never lost.
- id_valid=0 on load: behaves as a flush.
- Opcode decode, registered at load:
  - alu_op 00 -> 0010 (add)
  - alu_op 01 -> 0110 (sub)
  - alu_op 11 -> 0001 (or)
  - alu_op 10 by funct: 100100->0000, 100101->0001, 100000/100001->0010, 100110->0011, 000000->0100, 100010/100011->0110, 101010->0111, 100111->1100; any other funct -> 1111 (ALU passes a).
- Forwarding (combinational on registered addresses), applied to rs and rt independently:
  - If exmem_reg_write and exmem_rd!=0 and exmem_rd==src: use exmem_result.
  - Else if memwb_reg_write and memwb_rd!=0 and memwb_rd==src: use memwb_result.
  - Else: use the registered data.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded.
- a_operand = forwarded rs.
- b_operand = alu_src ? registered imm : forwarded rt.
- store_data = forwarded rt, independent of alu_src.
- dest_addr = reg_dst ? rd : rt (chosen at load).
- sa = registered shamt.
- Outputs are also valid while ex_valid=0, but the downstream stage ignores them.

Test Plan:
- Reset mid-run with ex_valid=1 -> all outputs 0 immediately, alu_opcode=0010, before any clock edge.
- Load R-type funct=101010, rs_data=5, rt_data=9, no hazards -> next cycle alu_opcode=0111, a=5, b=9, ex_valid=1.
- Registered rs=3, exmem (wr=1, rd=3, 0x11) and memwb (wr=1, rd=3, 0x22) -> a_operand=0x11. Drop exmem_reg_write -> a_operand=0x22. Repeat with rs=0 -> registered data, no forward.
- Hold stall=1 for 3 cycles with held rt=7. memwb writes rd=7, value 0xAB, in cycle 2, and no later forward is active -> b_operand=0xAB. sa, opcode and control unchanged throughout.
- stall=1 and flush=1 on the same edge -> bubble (ex_valid=0, reg_write=0, mem_write=0).
- Store: alu_op=00, alu_src=1, imm=0xFFFFFFFC, rt forwarded from exmem=0x1234 -> alu_opcode=0010, b=0xFFFFFFFC, store_data=0x1234.
